// File: rtl/sr165_frame_ctrl.sv
// Frame sequencer for an 8-bit PISO shift register: load one word, clock out WIDTH bits, frame the stream.
// Optional loopback compare of sr_q_h against the loaded word: define SR165_LOOPBACK_CHECK_EN.
module sr165_frame_ctrl #(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 0,
  parameter logic FILL_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             N_clr,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_last,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] sr_par_in,
  output logic             sr_shift_Nload,
  output logic             sr_clk_inh,
  output logic             sr_ser_in,
  output logic             sr_N_clr,
  input  logic             sr_q_h
);

  // state | meaning
  // IDLE  | waiting for start, register held
  // LOAD  | parallel load strobe, one cycle
  // SHIFT | WIDTH shift clocks, bit_out framed
  // GAP   | inter-frame idle time, register held
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [7:0]     GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       gap_cnt;
  logic             abort_pulse;
  logic             accept;

  assign ready          = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);
  assign bit_valid      = (state == ST_SHIFT);
  assign frame_last     = bit_valid && (bit_cnt == LAST_BIT);
  assign bit_out        = sr_q_h;
  assign sr_shift_Nload = (state != ST_LOAD);
  assign sr_clk_inh     = !((state == ST_LOAD) || (state == ST_SHIFT));
  assign sr_ser_in      = FILL_BIT;
  assign sr_N_clr       = N_clr & ~abort_pulse;
  // abort in IDLE only blocks acceptance
  assign accept         = ready && start && !abort;

  always_ff @(posedge clk or negedge N_clr) begin
    if (!N_clr) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      abort_pulse <= 1'b0;
      done        <= 1'b0;
      sr_par_in   <= '0;
    end else begin
      done        <= 1'b0;
      abort_pulse <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state       <= ST_IDLE;
        bit_cnt     <= '0;
        gap_cnt     <= '0;
        abort_pulse <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              sr_par_in <= data_in;
              state     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (bit_cnt == LAST_BIT) begin
              done    <= 1'b1;
              bit_cnt <= '0;
              gap_cnt <= GAP_LOAD;
              state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (gap_cnt == 8'd0) state <= ST_IDLE;
            else                 gap_cnt <= gap_cnt - 8'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SR165_LOOPBACK_CHECK_EN
  logic [CNT_W-1:0] exp_idx;
  logic             err_q;

  assign exp_idx = LAST_BIT - bit_cnt;
  assign err     = err_q;

  always_ff @(posedge clk or negedge N_clr) begin
    if (!N_clr) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state == ST_SHIFT) && (sr_q_h != sr_par_in[exp_idx])) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
